// File: rtl/mask_scan_acq.sv
// Mask-sweep acquisition sequencer: steps DMD mask indices, waits for the
// mask to be displayed, gates the APD counters after master sync, sums
// n_rep gates per mask into an internal buffer and hands off to Tx.
module mask_scan_acq #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 32,
  parameter int ADDR_W     = 14,
  parameter int MASK_W     = 8,
  parameter int FRAME_BITS = 2073600,
  parameter int TICK_STEP  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [MASK_W-1:0]       mask_fixed,
  input  logic [MASK_W-1:0]       mask_step,
  input  logic [15:0]             n_points,
  input  logic [7:0]              n_rep,
  input  logic                    vsync,
  input  logic                    master_sync,
  input  logic [31:0]             delay_det,
  input  logic [31:0]             width_det,
  input  logic [N_CH*CNT_W-1:0]   apd_cnt,
  output logic                    acc_sclr,
  output logic                    acc_en,
  output logic                    acc_latch,
  output logic [MASK_W-1:0]       mask_idx,
  output logic [31:0]             mask_offset,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [MASK_W-1:0]       rd_mask,
  output logic [N_CH*CNT_W-1:0]   rd_cnt,
  output logic                    tx_start,
  input  logic                    tx_ready,
  output logic                    busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LIM_W = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
  localparam logic [LIM_W-1:0] DEPTH_L   = LIM_W'(DEPTH);
  localparam logic [32:0]      TICK_INC  = 33'(TICK_STEP);
  localparam logic [31:0]      FRAME_W   = 32'(FRAME_BITS);
  localparam logic [2:0]       HOLD_LAST = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_FRAME, S_SETTLE, S_SYNC, S_DELAY,
    S_GATE, S_ACCUM, S_STORE, S_NEXT, S_TXWAIT
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W:0]                wptr_q, wptr_d;
  logic [7:0]                     rep_q, rep_d;
  logic [32:0]                    cnt_q, cnt_d;
  logic [2:0]                     hold_q, hold_d;
  logic [MASK_W-1:0]              mask_idx_q, mask_idx_d;
  logic [31:0]                    mask_offset_q, mask_offset_d;
  logic                           acc_sclr_q, acc_sclr_d;
  logic                           acc_en_q, acc_en_d;
  logic                           acc_latch_q, acc_latch_d;
  logic                           tx_start_q, tx_start_d;
  logic [N_CH-1:0][CNT_W-1:0]     sum_q, sum_d;
  logic [MASK_W-1:0]              rd_mask_q, rd_mask_d;
  logic [N_CH*CNT_W-1:0]          rd_cnt_q, rd_cnt_d;

  logic vs_s1_q, vs_s2_q, vs_s3_q, vs_p_q;
  logic vs_s1_d, vs_s2_d, vs_s3_d, vs_p_d;
  logic ms_s1_q, ms_s2_q, ms_s3_q, ms_p_q;
  logic ms_s1_d, ms_s2_d, ms_s3_d, ms_p_d;

  logic [MASK_W-1:0]              mem_mask [DEPTH];
  logic [N_CH*CNT_W-1:0]          mem_cnt  [DEPTH];

  logic                           we;
  logic [LIM_W-1:0]               limit;
  logic [7:0]                     nrep_eff;

  assign we       = (state_q == S_STORE) && !abort && !rst;
  assign limit    = (LIM_W'(n_points) > DEPTH_L) ? DEPTH_L : LIM_W'(n_points);
  assign nrep_eff = (n_rep == 8'd0) ? 8'd1 : n_rep;

  // Two-stage synchronisers plus registered rising-edge pulses for vsync and master sync
  always_comb begin
    vs_s1_d = vsync;
    vs_s2_d = vs_s1_q;
    vs_s3_d = vs_s2_q;
    vs_p_d  = vs_s2_q & ~vs_s3_q;
    ms_s1_d = master_sync;
    ms_s2_d = ms_s1_q;
    ms_s3_d = ms_s2_q;
    ms_p_d  = ms_s2_q & ~ms_s3_q;
  end

  // Sequencer next-state, accumulation and buffer read-port logic
  always_comb begin
    logic [CNT_W:0]   acc_sum;
    logic [CNT_W-1:0] base;
    acc_sum       = '0;
    base          = '0;
    state_d       = state_q;
    wptr_d        = wptr_q;
    rep_d         = rep_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    mask_idx_d    = mask_idx_q;
    mask_offset_d = 32'(mask_idx_q) * FRAME_W;
    acc_sclr_d    = acc_sclr_q;
    acc_en_d      = acc_en_q;
    acc_latch_d   = 1'b0;
    tx_start_d    = 1'b0;
    sum_d         = sum_q;
    // A write in the same cycle takes priority; the read registers hold their value.
    rd_mask_d     = we ? rd_mask_q : mem_mask[rd_addr];
    rd_cnt_d      = we ? rd_cnt_q  : mem_cnt[rd_addr];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wptr_d     = '0;
          mask_idx_d = mask_fixed;
          rep_d      = '0;
          state_d    = S_FRAME;
        end
      end
      S_FRAME: begin
        if (vs_p_q) begin
          if (LIM_W'(wptr_q) >= limit) begin
            tx_start_d = 1'b1;
            state_d    = S_TXWAIT;
          end else begin
            acc_sclr_d = 1'b1;
            state_d    = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (vs_p_q) begin
          acc_sclr_d = 1'b0;
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (ms_p_q) begin
          cnt_d   = '0;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q < {1'b0, delay_det}) begin
          cnt_d = cnt_q + 33'd1;
        end else begin
          acc_en_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_GATE;
        end
      end
      S_GATE: begin
        if (cnt_q < {1'b0, width_det}) begin
          cnt_d = cnt_q + TICK_INC;
        end else begin
          acc_en_d    = 1'b0;
          acc_sclr_d  = 1'b1;
          acc_latch_d = 1'b1;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_sclr_d = 1'b0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
          base     = (rep_q == 8'd0) ? '0 : sum_q[ch];
          acc_sum  = {1'b0, base} + {1'b0, apd_cnt[ch*CNT_W +: CNT_W]};
          sum_d[ch] = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
        end
        if (({1'b0, rep_q} + 9'd1) < {1'b0, nrep_eff}) begin
          rep_d   = rep_q + 8'd1;
          state_d = S_SYNC;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        hold_d  = '0;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 3'd1;
        end else begin
          wptr_d  = wptr_q + 1'b1;
          rep_d   = '0;
          state_d = S_FRAME;
          case (mode)
            2'd1:    mask_idx_d = mask_idx_q + MASK_W'(1);
            2'd2:    mask_idx_d = mask_idx_q + mask_step;
            default: mask_idx_d = mask_fixed;
          endcase
        end
      end
      S_TXWAIT: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort returns everything to its reset value; only the buffer array survives.
    if (abort) begin
      state_d       = S_IDLE;
      wptr_d        = '0;
      rep_d         = '0;
      cnt_d         = '0;
      hold_d        = '0;
      mask_idx_d    = '0;
      mask_offset_d = '0;
      acc_sclr_d    = 1'b0;
      acc_en_d      = 1'b0;
      acc_latch_d   = 1'b0;
      tx_start_d    = 1'b0;
      sum_d         = '0;
      rd_mask_d     = '0;
      rd_cnt_d      = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wptr_q        <= '0;
      rep_q         <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      mask_idx_q    <= '0;
      mask_offset_q <= '0;
      acc_sclr_q    <= 1'b0;
      acc_en_q      <= 1'b0;
      acc_latch_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      sum_q         <= '0;
      rd_mask_q     <= '0;
      rd_cnt_q      <= '0;
      vs_s1_q <= 1'b0; vs_s2_q <= 1'b0; vs_s3_q <= 1'b0; vs_p_q <= 1'b0;
      ms_s1_q <= 1'b0; ms_s2_q <= 1'b0; ms_s3_q <= 1'b0; ms_p_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rep_q         <= rep_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      mask_idx_q    <= mask_idx_d;
      mask_offset_q <= mask_offset_d;
      acc_sclr_q    <= acc_sclr_d;
      acc_en_q      <= acc_en_d;
      acc_latch_q   <= acc_latch_d;
      tx_start_q    <= tx_start_d;
      sum_q         <= sum_d;
      rd_mask_q     <= rd_mask_d;
      rd_cnt_q      <= rd_cnt_d;
      vs_s1_q <= vs_s1_d; vs_s2_q <= vs_s2_d; vs_s3_q <= vs_s3_d; vs_p_q <= vs_p_d;
      ms_s1_q <= ms_s1_d; ms_s2_q <= ms_s2_d; ms_s3_q <= ms_s3_d; ms_p_q <= ms_p_d;
    end
  end

  // Point buffer: one {mask, summed counts} record written per mask
  always_ff @(posedge clk) begin
    if (we) begin
      mem_mask[wptr_q[ADDR_W-1:0]] <= mask_idx_q;
      mem_cnt[wptr_q[ADDR_W-1:0]]  <= sum_q;
    end
  end

  assign acc_sclr    = acc_sclr_q;
  assign acc_en      = acc_en_q;
  assign acc_latch   = acc_latch_q;
  assign mask_idx    = mask_idx_q;
  assign mask_offset = mask_offset_q;
  assign rd_mask     = rd_mask_q;
  assign rd_cnt      = rd_cnt_q;
  assign tx_start    = tx_start_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mask_scan_acq.sv
// Directed bench for mask_scan_acq: table of sweep configurations plus
// hand-timed sequences for gate timing, abort and mid-sweep reset.
module tb_mask_scan_acq;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 14;
  localparam int MASK_W = 8;

  logic                   clk = 1'b0;
  logic                   rst, start, abort, tx_ready;
  logic [1:0]             mode;
  logic [MASK_W-1:0]      mask_fixed, mask_step;
  logic [15:0]            n_points;
  logic [7:0]             n_rep;
  logic                   vsync, master_sync;
  logic [31:0]            delay_det, width_det;
  logic [N_CH*CNT_W-1:0]  apd_cnt;
  logic                   acc_sclr, acc_en, acc_latch, tx_start, busy;
  logic [MASK_W-1:0]      mask_idx, rd_mask;
  logic [31:0]            mask_offset;
  logic [ADDR_W-1:0]      rd_addr;
  logic [N_CH*CNT_W-1:0]  rd_cnt;

  logic gen_en, gen_vs, gen_ms, man_vs, man_ms;
  int   gcyc;
  int   tx_cnt    = 0;
  int   gate_cnt  = 0;
  logic [31:0] lat_off = '0;
  int   errors = 0;
  int   checks = 0;

  assign vsync       = gen_en ? gen_vs : man_vs;
  assign master_sync = gen_en ? gen_ms : man_ms;

  always #5 clk = ~clk;

  mask_scan_acq #(
    .N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W),
    .FRAME_BITS(2073600), .TICK_STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .mask_fixed(mask_fixed), .mask_step(mask_step), .n_points(n_points),
    .n_rep(n_rep), .vsync(vsync), .master_sync(master_sync),
    .delay_det(delay_det), .width_det(width_det), .apd_cnt(apd_cnt),
    .acc_sclr(acc_sclr), .acc_en(acc_en), .acc_latch(acc_latch),
    .mask_idx(mask_idx), .mask_offset(mask_offset), .rd_addr(rd_addr),
    .rd_mask(rd_mask), .rd_cnt(rd_cnt), .tx_start(tx_start),
    .tx_ready(tx_ready), .busy(busy)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic [7:0]      mfix;
    logic [7:0]      mstep;
    logic [15:0]     np;
    logic [7:0]      nrep;
    logic [31:0]     apd0;
    logic [31:0]     apd1;
    logic [31:0]     dly;
    logic [31:0]     wid;
    logic [3:0][7:0] exp_mask;
    logic [31:0]     exp_c0;
    logic [31:0]     exp_c1;
    logic [7:0]      exp_gates;
    logic [31:0]     exp_off;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [1:0] md, input logic [7:0] mf, input logic [7:0] ms,
                              input logic [15:0] np, input logic [7:0] nr,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] dl, input logic [31:0] wd,
                              input logic [7:0] m0, input logic [7:0] m1,
                              input logic [7:0] m2, input logic [7:0] m3,
                              input logic [31:0] c0, input logic [31:0] c1,
                              input logic [7:0] ng, input logic [31:0] off);
    vec_t v;
    v.mode = md; v.mfix = mf; v.mstep = ms; v.np = np; v.nrep = nr;
    v.apd0 = a0; v.apd1 = a1; v.dly = dl; v.wid = wd;
    v.exp_mask = {m3, m2, m1, m0};
    v.exp_c0 = c0; v.exp_c1 = c1; v.exp_gates = ng; v.exp_off = off;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Free-running vsync / master sync sources
  initial begin
    gen_vs = 1'b0; gen_ms = 1'b0; gcyc = 0;
    forever begin
      @(posedge clk); #1;
      gcyc++;
      gen_vs = (gcyc % 40) < 20;
      gen_ms = (gcyc % 13) < 4;
    end
  end

  // Event counters for tx_start pulses and gate latches
  always @(negedge clk) begin
    if (tx_start) tx_cnt++;
    if (acc_latch) begin
      gate_cnt++;
      lat_off = mask_offset;
    end
  end

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic vs_pulse;
    man_vs = 1'b1;
    repeat (6) @(posedge clk);
    #1 man_vs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_sclr"},  acc_sclr, 0);
    chk({pfx, "_en"},    acc_en, 0);
    chk({pfx, "_latch"}, acc_latch, 0);
    chk({pfx, "_mask"},  mask_idx, 0);
    chk({pfx, "_off"},   mask_offset, 0);
    chk({pfx, "_tx"},    tx_start, 0);
    chk({pfx, "_busy"},  busy, 0);
    chk({pfx, "_rdm"},   rd_mask, 0);
    chk({pfx, "_rdc"},   rd_cnt, 0);
  endtask

  task automatic tx_handshake(input string pfx);
    tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    chk({pfx, "_busy_idle"}, busy, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   tx0, g0;
    logic seen;
    mode = v.mode; mask_fixed = v.mfix; mask_step = v.mstep;
    n_points = v.np; n_rep = v.nrep; delay_det = v.dly; width_det = v.wid;
    apd_cnt = {v.apd1, v.apd0};
    tx_ready = 1'b0;
    tx0 = tx_cnt; g0 = gate_cnt;
    gen_en = 1'b1;
    pulse_start;
    chk($sformatf("v%0d_busy_run", idx), busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    chk($sformatf("v%0d_tx_seen", idx), seen, 1);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_busy_txwait", idx), busy, 1);
    chk($sformatf("v%0d_tx_pulses", idx), 64'(tx_cnt - tx0), 1);
    chk($sformatf("v%0d_gates", idx), 64'(gate_cnt - g0), 64'(v.exp_gates));
    if (v.np != 16'd0) chk($sformatf("v%0d_last_offset", idx), lat_off, v.exp_off);
    tx_handshake($sformatf("v%0d", idx));
    gen_en = 1'b0;
    for (int i = 0; i < int'(v.np); i++) begin
      rd_addr = ADDR_W'(i);
      @(posedge clk); #1;
      chk($sformatf("v%0d_p%0d_mask", idx, i), rd_mask, v.exp_mask[i]);
      chk($sformatf("v%0d_p%0d_ch0", idx, i), rd_cnt[31:0], v.exp_c0);
      chk($sformatf("v%0d_p%0d_ch1", idx, i), rd_cnt[63:32], v.exp_c1);
    end
  endtask

  initial begin
    int first_en, en_len, latch_at, latch_len, tx0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    mode = '0; mask_fixed = '0; mask_step = '0; n_points = '0; n_rep = '0;
    delay_det = '0; width_det = '0; apd_cnt = '0; rd_addr = '0;
    gen_en = 1'b0; man_vs = 1'b0; man_ms = 1'b0;

    //          mode  fix   step  np  nrep apd0           apd1 dly wid  masks               ch0            ch1 gates offset
    vecs[0] = mk(2'd1, 8'd10, 8'd0, 16'd4, 8'd1, 32'd5, 32'd7, 32'd3, 32'd9, 8'd10, 8'd11, 8'd12, 8'd13, 32'd5, 32'd7, 8'd4, 32'd26956800);
    vecs[1] = mk(2'd2, 8'd250, 8'd4, 16'd3, 8'd1, 32'd100, 32'd200, 32'd2, 32'd4, 8'd250, 8'd254, 8'd2, 8'd0, 32'd100, 32'd200, 8'd3, 32'd4147200);
    vecs[2] = mk(2'd0, 8'd77, 8'd9, 16'd2, 8'd2, 32'd3, 32'd16, 32'd0, 32'd0, 8'd77, 8'd77, 8'd0, 8'd0, 32'd6, 32'd32, 8'd4, 32'd159667200);
    vecs[3] = mk(2'd3, 8'd5, 8'd1, 16'd2, 8'd0, 32'd9, 32'd1, 32'd1, 32'd3, 8'd5, 8'd5, 8'd0, 8'd0, 32'd9, 32'd1, 8'd2, 32'd10368000);
    vecs[4] = mk(2'd1, 8'd255, 8'd0, 16'd2, 8'd3, 32'hFFFF_FFF0, 32'd1, 32'd0, 32'd2, 8'd255, 8'd0, 8'd0, 8'd0, 32'hFFFF_FFFF, 32'd3, 8'd6, 32'd0);
    vecs[5] = mk(2'd1, 8'd20, 8'd0, 16'd0, 8'd1, 32'd1, 32'd1, 32'd0, 32'd0, 8'd0, 8'd0, 8'd0, 8'd0, 32'd0, 32'd0, 8'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("reset");

    // Gate timing: delay 3, width 9, master_sync raised just after edge 0
    mode = 2'd0; mask_fixed = 8'd42; n_points = 16'd1; n_rep = 8'd1;
    delay_det = 32'd3; width_det = 32'd9; apd_cnt = {32'd2, 32'd1};
    tx0 = tx_cnt;
    pulse_start;
    vs_pulse;
    chk("settle_sclr", acc_sclr, 1);
    vs_pulse;
    chk("sync_sclr", acc_sclr, 0);
    man_ms = 1'b1;
    first_en = 0; en_len = 0; latch_at = 0; latch_len = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (acc_en) begin
        if (first_en == 0) first_en = k;
        en_len++;
      end
      if (acc_latch) begin
        latch_at = k;
        latch_len++;
      end
      if (k == 14) chk("gate_end_sclr", acc_sclr, 1);
    end
    man_ms = 1'b0;
    chk("en_rise_clk", 64'(first_en), 8);
    chk("en_high_len", 64'(en_len), 6);
    chk("latch_clk", 64'(latch_at), 14);
    chk("latch_len", 64'(latch_len), 1);
    chk("fixed_mask", mask_idx, 42);
    chk("fixed_offset", mask_offset, 32'd87091200);
    repeat (10) @(posedge clk);
    #1;
    vs_pulse;
    chk("timing_tx", 64'(tx_cnt - tx0), 1);
    tx_handshake("timing");
    rd_addr = '0;
    @(posedge clk); #1;
    chk("timing_rd_mask", rd_mask, 42);
    chk("timing_rd_cnt", rd_cnt, {32'd2, 32'd1});

    // Abort while the gate is open
    width_det = 32'd100;
    pulse_start;
    vs_pulse;
    vs_pulse;
    man_ms = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pre_en", acc_en, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    man_ms = 1'b0;
    chk("abort_en", acc_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tx", tx_start, 0);
    chk("abort_sclr", acc_sclr, 0);
    tx0 = tx_cnt;
    gen_en = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_tx", 64'(tx_cnt - tx0), 0);
    chk("abort_idle", busy, 0);
    gen_en = 1'b0;
    rd_addr = '0;
    @(posedge clk); #1;
    chk("abort_buf_kept", rd_cnt, {32'd2, 32'd1});

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Reset in the middle of a sweep
    mode = vecs[0].mode; mask_fixed = vecs[0].mfix; n_points = vecs[0].np;
    n_rep = vecs[0].nrep; delay_det = vecs[0].dly; width_det = vecs[0].wid;
    gen_en = 1'b1;
    pulse_start;
    repeat (150) @(posedge clk);
    #1;
    chk("midsweep_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_zero("midrst");
    gen_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
